// File: rtl/rv_core_pkg.sv
// Shared core widths and register-address/word types.
package rv_core_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int NREGS  = 1 << REG_AW;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]   word_t;

   localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/reg_scoreboard.sv
// In-flight destination tracker, one pending bit per register (x0 never pending).
// Queries are combinational on current state; a set and clear of the same register in one cycle leaves it set.
module reg_scoreboard
   import rv_core_pkg::*;
(
   input  logic      clk,
   input  logic      reset_n,
   input  logic      set_en,
   input  reg_addr_t set_rd,
   input  logic      clr_en,
   input  reg_addr_t clr_rd,
   input  reg_addr_t rs1,
   input  reg_addr_t rs2,
   input  reg_addr_t rd,
   output logic      rs1_pend,
   output logic      rs2_pend,
   output logic      rd_pend
);

   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] set_mask;
   logic [NREGS-1:0] clr_mask;

   always_comb begin
      set_mask         = '0;
      clr_mask         = '0;
      set_mask[set_rd] = set_en;
      clr_mask[clr_rd] = clr_en;
      set_mask[0]      = 1'b0;
   end

   // Set is OR-ed after the clear so an issue and a commit to the same register keep it pending.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clr_mask) | set_mask;
      end
   end

   assign rs1_pend = pending[rs1];
   assign rs2_pend = pending[rs2];
   assign rd_pend  = pending[rd];

endmodule

// File: rtl/reg_access_ctrl.sv
// Regfile operand fetch / writeback commit: arbitrates writes (mem over alu), stalls RAW/WAW, bypasses commits.
// Operands land in the execute slot one cycle after issue; the slot holds while ex_valid & ~ex_ready.
module reg_access_ctrl
   import rv_core_pkg::*;
(
   input  logic      clk,
   input  logic      reset_n,

   input  logic      id_valid,
   output logic      id_ready,
   input  reg_addr_t id_rs1,
   input  reg_addr_t id_rs2,
   input  logic      id_use_rs1,
   input  logic      id_use_rs2,
   input  reg_addr_t id_rd,
   input  logic      id_wr,

   output reg_addr_t rf_rs1,
   output reg_addr_t rf_rs2,
   output logic      rf_renb1,
   output logic      rf_renb2,
   input  word_t     rf_rdata1,
   input  word_t     rf_rdata2,
   output reg_addr_t rf_rd,
   output logic      rf_wenb,
   output word_t     rf_wdata,

   output logic      ex_valid,
   input  logic      ex_ready,
   output word_t     ex_op1,
   output word_t     ex_op2,
   output reg_addr_t ex_rd,
   output logic      ex_wr,

   input  logic      alu_wb_valid,
   input  reg_addr_t alu_wb_rd,
   input  word_t     alu_wb_data,
   output logic      alu_wb_ready,

   input  logic      mem_wb_valid,
   input  reg_addr_t mem_wb_rd,
   input  word_t     mem_wb_data
);

   logic  commit;
   logic  rs1_pend, rs2_pend, rd_pend;
   logic  rs1_byp, rs2_byp, rd_byp;
   logic  rs1_blk, rs2_blk, waw_blk;
   logic  slot_stall;
   logic  issue;
   word_t op1_nxt, op2_nxt;

   assign rf_rs1   = id_rs1;
   assign rf_rs2   = id_rs2;
   assign rf_renb1 = id_valid & id_use_rs1;
   assign rf_renb2 = id_valid & id_use_rs2;

   // Memory results cannot be backpressured, so they always take the single write port.
   assign alu_wb_ready = ~mem_wb_valid;
   assign commit       = mem_wb_valid | alu_wb_valid;
   assign rf_rd        = mem_wb_valid ? mem_wb_rd   : alu_wb_rd;
   assign rf_wdata     = mem_wb_valid ? mem_wb_data : alu_wb_data;
   assign rf_wenb      = commit & (rf_rd != REG_ZERO);

   reg_scoreboard u_scoreboard (
      .clk      (clk),
      .reset_n  (reset_n),
      .set_en   (issue & id_wr & (id_rd != REG_ZERO)),
      .set_rd   (id_rd),
      .clr_en   (rf_wenb),
      .clr_rd   (rf_rd),
      .rs1      (id_rs1),
      .rs2      (id_rs2),
      .rd       (id_rd),
      .rs1_pend (rs1_pend),
      .rs2_pend (rs2_pend),
      .rd_pend  (rd_pend)
   );

   assign rs1_byp = rf_wenb & (rf_rd == id_rs1);
   assign rs2_byp = rf_wenb & (rf_rd == id_rs2);
   assign rd_byp  = rf_wenb & (rf_rd == id_rd);

   // A hazard resolves in the very cycle its commit appears on the write port.
   assign rs1_blk = id_use_rs1 & (id_rs1 != REG_ZERO) & rs1_pend & ~rs1_byp;
   assign rs2_blk = id_use_rs2 & (id_rs2 != REG_ZERO) & rs2_pend & ~rs2_byp;
   assign waw_blk = id_wr & (id_rd != REG_ZERO) & rd_pend & ~rd_byp;

   assign slot_stall = ex_valid & ~ex_ready;
   assign id_ready   = ~slot_stall & ~rs1_blk & ~rs2_blk & ~waw_blk;
   assign issue      = id_valid & id_ready;

   function automatic word_t sel_op(input logic use_rs, input reg_addr_t rs,
                                    input logic byp, input word_t wdata, input word_t rdata);
      if (!use_rs || rs == REG_ZERO) begin
         return '0;
      end else if (byp) begin
         return wdata;
      end else begin
         return rdata;
      end
   endfunction

   assign op1_nxt = sel_op(id_use_rs1, id_rs1, rs1_byp, rf_wdata, rf_rdata1);
   assign op2_nxt = sel_op(id_use_rs2, id_rs2, rs2_byp, rf_wdata, rf_rdata2);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_valid <= 1'b0;
         ex_op1   <= '0;
         ex_op2   <= '0;
         ex_rd    <= '0;
         ex_wr    <= 1'b0;
      end else if (issue) begin
         ex_valid <= 1'b1;
         ex_op1   <= op1_nxt;
         ex_op2   <= op2_nxt;
         ex_rd    <= id_rd;
         ex_wr    <= id_wr;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

endmodule
